// File: rtl/stall_ctrl.sv
// Pipeline sequencing controller: load-use detection, multi-cycle divider
// sequencing and memory-stall merge into one per-stage stall bus.
module stall_ctrl #(
  parameter int STALL_W    = 6,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         id_rs,
  input  logic               id_rs_used,
  input  logic [4:0]         id_rt,
  input  logic               id_rt_used,
  input  logic               id_rf_we,
  input  logic [4:0]         id_waddr,
  input  logic               id_is_load,
  input  logic               id_is_div,
  input  logic               mem_stallreq,
  output logic [STALL_W-1:0] stall,
  output logic               load_use_stall,
  output logic               div_start,
  output logic               div_busy,
  output logic               div_done,
  output logic               ex_wv,
  output logic [4:0]         ex_waddr,
  output logic               mem_wv,
  output logic [4:0]         mem_waddr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       ex_v_q, ex_v_d;
  logic [4:0] ex_waddr_q, ex_waddr_d;
  logic       ex_load_q, ex_load_d;
  logic       mem_v_q, mem_v_d;
  logic [4:0] mem_waddr_q, mem_waddr_d;

  logic load_use;

  // A load still in EX cannot forward to the instruction reading it in ID.
  always_comb begin
    load_use = id_valid & ex_v_q & ex_load_q & (ex_waddr_q != 5'd0) &
               ((id_rs_used & (id_rs == ex_waddr_q)) |
                (id_rt_used & (id_rt == ex_waddr_q)));
  end

  always_comb begin
    stall = '0;
    if (mem_stallreq)
      stall = STALL_W'(6'b011111);
    else if (state_q == BUSY)
      stall = STALL_W'(6'b001111);
    else if (load_use)
      stall = STALL_W'(6'b000111);
  end

  assign div_start = (state_q != BUSY) & id_valid & id_is_div & ~stall[2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_start) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0)
          state_d = DONE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      DONE: begin
        // The result is only consumed once memory lets EX advance.
        if (!mem_stallreq) begin
          div_done = 1'b1;
          if (div_start) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // EX/MEM write tracking: advance, insert a bubble, or hold.
  always_comb begin
    ex_v_d      = ex_v_q;
    ex_waddr_d  = ex_waddr_q;
    ex_load_d   = ex_load_q;
    mem_v_d     = mem_v_q;
    mem_waddr_d = mem_waddr_q;
    if (!stall[2]) begin
      ex_v_d     = id_valid & id_rf_we;
      ex_waddr_d = id_waddr;
      ex_load_d  = id_is_load;
    end else if (!stall[3]) begin
      ex_v_d     = 1'b0;
      ex_waddr_d = 5'd0;
      ex_load_d  = 1'b0;
    end
    if (!stall[3]) begin
      mem_v_d     = ex_v_q;
      mem_waddr_d = ex_waddr_q;
    end else if (!stall[4]) begin
      mem_v_d     = 1'b0;
      mem_waddr_d = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ex_v_q      <= 1'b0;
      ex_waddr_q  <= 5'd0;
      ex_load_q   <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_waddr_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_v_q      <= ex_v_d;
      ex_waddr_q  <= ex_waddr_d;
      ex_load_q   <= ex_load_d;
      mem_v_q     <= mem_v_d;
      mem_waddr_q <= mem_waddr_d;
    end
  end

  assign load_use_stall = load_use;
  assign div_busy       = (state_q == BUSY);
  assign ex_wv          = ex_v_q;
  assign ex_waddr       = ex_waddr_q;
  assign mem_wv         = mem_v_q;
  assign mem_waddr      = mem_waddr_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed vector table, multi-cycle divider/reset
// sequences, then randomized traffic against a behavioural pipeline model.
module tb_stall_ctrl;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_rf_we, id_is_load, id_is_div;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       mem_stallreq;
  logic [5:0] stall;
  logic       load_use_stall, div_start, div_busy, div_done;
  logic       ex_wv, mem_wv;
  logic [4:0] ex_waddr, mem_waddr;

  always #5 clk = ~clk;

  stall_ctrl #(.STALL_W(6), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rf_we(id_rf_we),
    .id_waddr(id_waddr), .id_is_load(id_is_load), .id_is_div(id_is_div),
    .mem_stallreq(mem_stallreq), .stall(stall), .load_use_stall(load_use_stall),
    .div_start(div_start), .div_busy(div_busy), .div_done(div_done),
    .ex_wv(ex_wv), .ex_waddr(ex_waddr), .mem_wv(mem_wv), .mem_waddr(mem_waddr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [21:0] pk(input logic [5:0] s, input logic lu,
      input logic st, input logic bz, input logic dn, input logic exv,
      input logic [4:0] exa, input logic memv, input logic [4:0] mema);
    return {s, lu, st, bz, dn, exv, exa, memv, mema};
  endfunction

  function automatic logic [21:0] outs();
    return {stall, load_use_stall, div_start, div_busy, div_done,
            ex_wv, ex_waddr, mem_wv, mem_waddr};
  endfunction

  task automatic check(input string nm, input logic [21:0] got, input logic [21:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {stall,lu,start,busy,done,exv,exa,memv,mema}=%h expected %h",
                  nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input string nm, input logic [21:0] exp);
    @(negedge clk);
    check(nm, outs(), exp);
    tick();
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_rf_we = 0; id_waddr = 0; id_is_load = 0; id_is_div = 0; mem_stallreq = 0;
  endtask

  task automatic set_div(input logic [4:0] wa);
    set_idle();
    id_valid = 1; id_is_div = 1; id_rf_we = 1; id_waddr = wa;
  endtask

  typedef struct {
    logic idv; logic [4:0] rs; logic rsu; logic [4:0] rt; logic rtu;
    logic we; logic [4:0] wa; logic ld; logic ms;
    logic [5:0] s; logic lu; logic exv; logic [4:0] exa; logic memv; logic [4:0] mema;
  } vec_t;

  function automatic vec_t mk(input logic idv, input logic [4:0] rs, input logic rsu,
      input logic [4:0] rt, input logic rtu, input logic we, input logic [4:0] wa,
      input logic ld, input logic ms, input logic [5:0] s, input logic lu,
      input logic exv, input logic [4:0] exa, input logic memv, input logic [4:0] mema);
    vec_t v;
    v.idv = idv; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu; v.we = we;
    v.wa = wa; v.ld = ld; v.ms = ms; v.s = s; v.lu = lu; v.exv = exv;
    v.exa = exa; v.memv = memv; v.mema = mema;
    return v;
  endfunction

  // Behavioural model: pipeline entries as records, divider as a
  // remaining-busy-cycle count plus a result-waiting flag.
  typedef struct packed { logic v; logic [4:0] wa; logic ld; } ent_t;
  ent_t m_ex, m_mem;
  int   m_left;
  bit   m_pend;

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_left = 0; m_pend = 0;
  endtask

  task automatic model_eval(output logic [21:0] exp, output logic [5:0] s,
                            output bit st, output bit dn);
    bit busy, lu;
    busy = (m_left > 0);
    lu = id_valid && m_ex.v && m_ex.ld && (m_ex.wa != 0) &&
         ((id_rs_used && id_rs == m_ex.wa) || (id_rt_used && id_rt == m_ex.wa));
    s  = mem_stallreq ? 6'h1f : busy ? 6'h0f : lu ? 6'h07 : 6'h00;
    st = id_valid && id_is_div && !s[2] && !busy;
    dn = m_pend && !mem_stallreq;
    exp = pk(s, lu, st, busy, dn, m_ex.v, m_ex.wa, m_mem.v, m_mem.wa);
  endtask

  task automatic model_update(input logic [5:0] s, input bit st, input bit dn);
    ent_t ex_n, mem_n;
    if (rst) begin
      model_reset();
      return;
    end
    ex_n = m_ex; mem_n = m_mem;
    if (!s[2]) ex_n = '{v: id_valid & id_rf_we, wa: id_waddr, ld: id_is_load};
    else if (!s[3]) ex_n = '0;
    if (!s[3]) mem_n = m_ex;
    else if (!s[4]) mem_n = '0;
    m_ex = ex_n; m_mem = mem_n;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_pend = 1;
    end else if (dn) begin
      m_pend = 0;
    end
    if (st) begin
      m_left = DIV;
      m_pend = 0;
    end
  endtask

  vec_t tbl[12];

  initial begin
    logic [21:0] exp;
    logic [5:0]  ms_s;
    bit          m_st, m_dn;

    set_idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    step("reset_state", 22'd0);

    //      idv rs rsu rt rtu we wa ld ms | stall lu exv exa memv mema
    tbl[0]  = mk(1, 1, 1, 0, 0, 1,  8, 1, 0, 6'h00, 0, 0,  0, 0,  0);
    tbl[1]  = mk(1, 8, 1, 0, 0, 1,  9, 0, 0, 6'h07, 1, 1,  8, 0,  0);
    tbl[2]  = mk(1, 8, 1, 0, 0, 1,  9, 0, 0, 6'h00, 0, 0,  0, 1,  8);
    tbl[3]  = mk(1, 2, 1, 0, 0, 1,  0, 1, 0, 6'h00, 0, 1,  9, 0,  0);
    tbl[4]  = mk(1, 0, 1, 0, 1, 1, 10, 0, 0, 6'h00, 0, 1,  0, 1,  9);
    tbl[5]  = mk(1, 3, 1, 0, 0, 1,  8, 1, 0, 6'h00, 0, 1, 10, 1,  0);
    tbl[6]  = mk(1, 5, 1, 8, 0, 1, 12, 0, 0, 6'h00, 0, 1,  8, 1, 10);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1,  7, 1, 0, 6'h00, 0, 1, 12, 1,  8);
    tbl[8]  = mk(1, 0, 0, 7, 1, 1, 11, 0, 1, 6'h1f, 1, 1,  7, 1, 12);
    tbl[9]  = mk(1, 0, 0, 7, 1, 1, 11, 0, 1, 6'h1f, 1, 1,  7, 1, 12);
    tbl[10] = mk(1, 0, 0, 7, 1, 1, 11, 0, 0, 6'h07, 1, 1,  7, 1, 12);
    tbl[11] = mk(1, 0, 0, 7, 1, 1, 11, 0, 0, 6'h00, 0, 0,  0, 1,  7);

    for (int i = 0; i < 12; i++) begin
      id_valid = tbl[i].idv; id_rs = tbl[i].rs; id_rs_used = tbl[i].rsu;
      id_rt = tbl[i].rt; id_rt_used = tbl[i].rtu; id_rf_we = tbl[i].we;
      id_waddr = tbl[i].wa; id_is_load = tbl[i].ld; id_is_div = 0;
      mem_stallreq = tbl[i].ms;
      step($sformatf("vec%0d", i), pk(tbl[i].s, tbl[i].lu, 0, 0, 0, tbl[i].exv,
                                       tbl[i].exa, tbl[i].memv, tbl[i].mema));
    end

    // Plain divide: start at T, four busy cycles, done at T+5.
    set_div(3);
    step("div_T", pk(6'h00, 0, 1, 0, 0, 1, 11, 0, 0));
    set_idle();
    for (int k = 1; k <= DIV; k++)
      step($sformatf("div_busy%0d", k),
           pk(6'h0f, 0, 0, 1, 0, 1, 3, (k == 1), (k == 1) ? 5'd11 : 5'd0));
    step("div_done", pk(6'h00, 0, 0, 0, 1, 1, 3, 0, 0));
    step("div_after", pk(6'h00, 0, 0, 0, 0, 0, 0, 1, 3));

    // Divide ending under a memory stall, then a back-to-back divide.
    set_div(4);
    step("mdiv_T", pk(6'h00, 0, 1, 0, 0, 0, 0, 0, 0));
    set_idle();
    for (int k = 1; k < DIV; k++)
      step($sformatf("mdiv_busy%0d", k), pk(6'h0f, 0, 0, 1, 0, 1, 4, 0, 0));
    mem_stallreq = 1;
    step("mdiv_busy_ms", pk(6'h1f, 0, 0, 1, 0, 1, 4, 0, 0));
    step("mdiv_done_held1", pk(6'h1f, 0, 0, 0, 0, 1, 4, 0, 0));
    step("mdiv_done_held2", pk(6'h1f, 0, 0, 0, 0, 1, 4, 0, 0));
    set_div(5);
    step("b2b_done_start", pk(6'h00, 0, 1, 0, 1, 1, 4, 0, 0));
    set_idle();
    step("b2b_busy1", pk(6'h0f, 0, 0, 1, 0, 1, 5, 1, 4));
    for (int k = 2; k <= DIV; k++)
      step($sformatf("b2b_busy%0d", k), pk(6'h0f, 0, 0, 1, 0, 1, 5, 0, 0));
    step("b2b_done", pk(6'h00, 0, 0, 0, 1, 1, 5, 0, 0));

    // Reset arriving mid-divide.
    set_div(6);
    step("rdiv_T", pk(6'h00, 0, 1, 0, 0, 0, 0, 1, 5));
    set_idle();
    step("rdiv_busy1", pk(6'h0f, 0, 0, 1, 0, 1, 6, 0, 0));
    step("rdiv_busy2", pk(6'h0f, 0, 0, 1, 0, 1, 6, 0, 0));
    rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < DIV + 2; k++)
      step($sformatf("rdiv_post%0d", k), 22'd0);

    // Randomized traffic against the model.
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      id_valid     = ($urandom_range(0, 9) < 8);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_waddr     = 5'($urandom_range(0, 3));
      id_rs_used   = 1'($urandom_range(0, 1));
      id_rt_used   = 1'($urandom_range(0, 1));
      id_rf_we     = ($urandom_range(0, 3) != 0);
      id_is_load   = ($urandom_range(0, 2) == 0);
      id_is_div    = ($urandom_range(0, 9) == 0);
      mem_stallreq = ($urandom_range(0, 6) == 0);
      model_eval(exp, ms_s, m_st, m_dn);
      @(negedge clk);
      check($sformatf("rand%0d", i), outs(), exp);
      @(posedge clk);
      model_update(ms_s, m_st, m_dn);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
